// File: rtl/fifo_pkg.sv
// Shared helpers and mode encoding for the single-clock threshold FIFO.
package fifo_pkg;

  // Read-side behaviour: registered read data or first-word-fall-through head.
  typedef enum int {
    STD  = 0,
    FWFT = 1
  } fifo_mode_e;

  // Address width: enough bits to index every entry.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer width: address bits plus one wrap bit so full and empty differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Storage array for the single-clock FIFO: synchronous write, asynchronous read.
module sfifo_mem
  import fifo_pkg::*;
#(
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [addr_w(depth)-1:0] waddr,
  input  logic [data_width-1:0]    wdata,
  input  logic [addr_w(depth)-1:0] raddr,
  output logic [data_width-1:0]    rdata
);

  logic [data_width-1:0] mem [depth];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// synchronous flush, optional first-word-fall-through read and sticky errors.
module sync_fifo_thresh
  import fifo_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int depth         = 16,
  parameter int afull_thresh  = depth - 2,
  parameter int aempty_thresh = 2,
  parameter int fwft          = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    w_en,
  input  logic [data_width-1:0]   data_in,
  input  logic                    r_en,
  output logic [data_width-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ptr_w(depth)-1:0] count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int AW = addr_w(depth);
  localparam int PW = ptr_w(depth);

  if ((depth < 4) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_thresh: depth must be a power of 2 and at least 4");
  end
  if ((afull_thresh < 1) || (afull_thresh > depth)) begin : g_bad_afull
    $error("sync_fifo_thresh: afull_thresh must be in 1..depth");
  end
  if ((aempty_thresh < 0) || (aempty_thresh > depth - 1)) begin : g_bad_aempty
    $error("sync_fifo_thresh: aempty_thresh must be in 0..depth-1");
  end

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic                  ovf_set, udf_set;
  logic [data_width-1:0] head;

  // Occupancy and flags come straight from the registered pointers.
  assign count        = wptr_q - rptr_q;
  assign full         = (count == PW'(depth));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PW'(afull_thresh));
  assign almost_empty = (count <= PW'(aempty_thresh));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Accept/reject decisions, pointer advance, flush and sticky error update.
  always_comb begin
    wr_acc  = w_en && !full && !flush;
    rd_acc  = r_en && !empty && !flush;
    ovf_set = w_en && full && !flush;
    udf_set = r_en && empty && !flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PW'(1);
      if (rd_acc) rptr_d = rptr_q + PW'(1);
    end
    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q && !clr_err) || ovf_set;
    udf_d = (udf_q && !clr_err) || udf_set;
  end

  // Pointer and error-flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  sfifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (rptr_q[AW-1:0]),
    .rdata (head)
  );

  if (fwft == int'(FWFT)) begin : g_fwft
    // Head of the queue is presented directly; r_en only acknowledges it.
    assign data_out = head;
  end else begin : g_std
    logic [data_width-1:0] dout_q, dout_d;

    // Capture the head on an accepted read, otherwise hold.
    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = head;
    end

    // Registered read data, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule
